// File: rtl/nav_controller.sv
// Obstacle-avoidance decision stage: debounces three obstacle sensors and drives the wheel code.
// Define NAV_TIMEOUT_EN to add the BLOCKED dwell timeout with an escape U-turn.
module nav_controller #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TURN_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES  = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic       halt,
  input  logic       obs_left,
  input  logic       obs_front,
  input  logic       obs_right,
  output logic [1:0] state,
  output logic       busy,
  output logic       blocked
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FORWARD,
    S_TURN_L,
    S_TURN_R,
    S_BLOCKED
  } fsm_t;

  typedef enum logic [1:0] {
    W_FORWARD = 2'b00,
    W_RIGHT   = 2'b01,
    W_LEFT    = 2'b10,
    W_STOP    = 2'b11
  } wheel_t;

  if (DEBOUNCE_CYCLES < 1 || TURN_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("nav_controller: cycle parameters must be >= 1");
  end

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

`ifdef NAV_TIMEOUT_EN
  localparam int TURN_MAX = 2 * TURN_CYCLES;
`else
  localparam int TURN_MAX = TURN_CYCLES;
`endif
  localparam int TURN_W = $clog2(TURN_MAX + 1);
  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYCLES - 1);

`ifdef NAV_TIMEOUT_EN
  localparam int DWELL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TURN_W-1:0]  UTURN_LOAD = TURN_W'(2 * TURN_CYCLES - 1);
`endif

  // Sensor bit order throughout: [2]=left, [1]=front, [0]=right.
  logic [2:0]      sync1_q, sync1_d;
  logic [2:0]      sync2_q, sync2_d;
  logic [2:0]      db_q, db_d;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    sync1_d = {obs_left, obs_front, obs_right};
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        // The counter is cleared on acceptance, so it can never run past DB_LAST.
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  logic left_db, front_db, right_db;
  assign left_db  = db_q[2];
  assign front_db = db_q[1];
  assign right_db = db_q[0];

  fsm_t              fsm_q, fsm_d;
  logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
  wheel_t            wheel_q, wheel_d;
  logic              busy_q, busy_d;
  logic              blocked_q, blocked_d;
`ifdef NAV_TIMEOUT_EN
  logic [DWELL_W-1:0] dwell_q, dwell_d;
`endif

  always_comb begin
    fsm_d      = fsm_q;
    turn_cnt_d = turn_cnt_q;
`ifdef NAV_TIMEOUT_EN
    dwell_d    = dwell_q;
`endif
    if (halt) begin
      fsm_d      = S_IDLE;
      turn_cnt_d = '0;
`ifdef NAV_TIMEOUT_EN
      dwell_d    = '0;
`endif
    end else begin
      case (fsm_q)
        S_IDLE: if (go) fsm_d = S_FORWARD;
        S_FORWARD: begin
          if (front_db) begin
            if (!left_db) begin
              fsm_d      = S_TURN_L;
              turn_cnt_d = TURN_LOAD;
            end else if (!right_db) begin
              fsm_d      = S_TURN_R;
              turn_cnt_d = TURN_LOAD;
            end else begin
              fsm_d = S_BLOCKED;
`ifdef NAV_TIMEOUT_EN
              dwell_d = '0;
`endif
            end
          end
        end
        S_TURN_L, S_TURN_R: begin
          // Loaded with length-1 at entry; the zero cycle is the last one spent turning.
          if (turn_cnt_q == '0) fsm_d = S_FORWARD;
          else turn_cnt_d = turn_cnt_q - TURN_W'(1);
        end
        S_BLOCKED: begin
          if (!front_db) begin
            fsm_d = S_FORWARD;
`ifdef NAV_TIMEOUT_EN
          end else if (dwell_q == DWELL_LAST) begin
            fsm_d      = S_TURN_R;
            turn_cnt_d = UTURN_LOAD;
            dwell_d    = '0;
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
`endif
          end
        end
        default: fsm_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state and registered alongside it.
    case (fsm_d)
      S_FORWARD: wheel_d = W_FORWARD;
      S_TURN_L:  wheel_d = W_LEFT;
      S_TURN_R:  wheel_d = W_RIGHT;
      default:   wheel_d = W_STOP;
    endcase
    busy_d    = (fsm_d != S_IDLE);
    blocked_d = (fsm_d == S_BLOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q      <= S_IDLE;
      turn_cnt_q <= '0;
      wheel_q    <= W_STOP;
      busy_q     <= 1'b0;
      blocked_q  <= 1'b0;
`ifdef NAV_TIMEOUT_EN
      dwell_q    <= '0;
`endif
    end else begin
      fsm_q      <= fsm_d;
      turn_cnt_q <= turn_cnt_d;
      wheel_q    <= wheel_d;
      busy_q     <= busy_d;
      blocked_q  <= blocked_d;
`ifdef NAV_TIMEOUT_EN
      dwell_q    <= dwell_d;
`endif
    end
  end

  assign state   = wheel_q;
  assign busy    = busy_q;
  assign blocked = blocked_q;

endmodule

// File: tb/tb_nav_controller.sv
// Scoreboard bench for nav_controller: the driver queues each expected output change with its
// cycle, and a monitor pops and compares every change the DUT presents.
module tb_nav_controller;

  localparam int DB = 4;
  localparam int TC = 10;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst_n, go, halt, obs_left, obs_front, obs_right;
  logic [1:0] state;
  logic       busy, blocked;

  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] out;
    int         cyc;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  nav_controller #(
    .DEBOUNCE_CYCLES(DB),
    .TURN_CYCLES    (TC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .go       (go),
    .halt     (halt),
    .obs_left (obs_left),
    .obs_front(obs_front),
    .obs_right(obs_right),
    .state    (state),
    .busy     (busy),
    .blocked  (blocked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_at(input string name, input logic [1:0] st, input logic b,
                           input logic bl, input int at);
    exp_t e;
    e.out  = {st, b, bl};
    e.cyc  = at;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: any change of {state,busy,blocked} must match the next queued expectation.
  initial begin
    logic [3:0] prev, cur;
    exp_t e;
    repeat (2) @(negedge clk);
    prev = {state, busy, blocked};
    forever begin
      @(negedge clk);
      cur = {state, busy, blocked};
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_change: got %b at cycle %0d, expected it to stay %b",
                   cur, cyc, prev);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_out"}, 32'(cur), 32'(e.out));
          check({e.name, "_cycle"}, cyc, e.cyc);
        end
        prev = cur;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    rst_n = 1'b0; go = 1'b0; halt = 1'b0;
    obs_left = 1'b0; obs_front = 1'b0; obs_right = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", 32'(state), 32'(2'b11));
    check("reset_busy", 32'(busy), 0);
    check("reset_blocked", 32'(blocked), 0);
    rst_n = 1'b1;
    @(negedge clk);

    expect_at("go_forward", 2'b00, 1'b1, 1'b0, cyc + 1);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a cycle
    expect_at("async_reset", 2'b11, 1'b0, 1'b0, cyc + 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_state_now", 32'(state), 32'(2'b11));
    check("async_reset_busy_now", 32'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    expect_at("go_after_reset", 2'b00, 1'b1, 1'b0, cyc + 1);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (2) @(negedge clk);

    // Front pulse of 3 synchronized cycles must be rejected
    t = cyc;
    obs_front = 1'b1;
    wait_until(t + 3);
    obs_front = 1'b0;
    wait_until(t + 12);

    // Left turn: decision 7 cycles after the raw edge, then 10 cycles of turning
    t = cyc;
    expect_at("turn_left", 2'b10, 1'b1, 1'b0, t + 7);
    expect_at("left_done", 2'b00, 1'b1, 1'b0, t + 17);
    obs_front = 1'b1;
    wait_until(t + 9);
    obs_front = 1'b0;
    wait_until(t + 22);

    // go while moving is ignored
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);

    // Right turn: left side also obstructed
    t = cyc;
    expect_at("turn_right", 2'b01, 1'b1, 1'b0, t + 7);
    expect_at("right_done", 2'b00, 1'b1, 1'b0, t + 17);
    obs_front = 1'b1;
    obs_left  = 1'b1;
    wait_until(t + 9);
    obs_front = 1'b0;
    obs_left  = 1'b0;
    wait_until(t + 22);

    // All three obstructed
    t = cyc;
    expect_at("blocked", 2'b11, 1'b1, 1'b1, t + 7);
    obs_left  = 1'b1;
    obs_front = 1'b1;
    obs_right = 1'b1;
`ifdef NAV_TIMEOUT_EN
    expect_at("escape_uturn", 2'b01, 1'b1, 1'b0, t + 7 + TO);
    expect_at("uturn_done", 2'b00, 1'b1, 1'b0, t + 7 + TO + 2 * TC);
    wait_until(t + 30);
    obs_left  = 1'b0;
    obs_front = 1'b0;
    obs_right = 1'b0;
    wait_until(t + 52);
`else
    wait_until(t + 30);
    t = cyc;
    expect_at("front_clear", 2'b00, 1'b1, 1'b0, t + 7);
    obs_front = 1'b0;
    wait_until(t + 9);
    obs_left  = 1'b0;
    obs_right = 1'b0;
    wait_until(t + 15);
`endif

    // Halt sampled on the 5th cycle of a left turn
    t = cyc;
    expect_at("halt_turn_entry", 2'b10, 1'b1, 1'b0, t + 7);
    expect_at("halt_mid_turn", 2'b11, 1'b0, 1'b0, t + 12);
    obs_front = 1'b1;
    wait_until(t + 11);
    halt      = 1'b1;
    obs_front = 1'b0;
    wait_until(t + 13);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("go_halt_state", 32'(state), 32'(2'b11));
    check("go_halt_busy", 32'(busy), 0);
    @(negedge clk);
    halt = 1'b0;
    wait_until(t + 20);

    expect_at("go_after_halt", 2'b00, 1'b1, 1'b0, cyc + 1);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (2) @(negedge clk);

    // A full-length turn after the aborted one
    t = cyc;
    expect_at("turn_left_again", 2'b10, 1'b1, 1'b0, t + 7);
    expect_at("left_again_done", 2'b00, 1'b1, 1'b0, t + 17);
    obs_front = 1'b1;
    wait_until(t + 9);
    obs_front = 1'b0;
    wait_until(t + 20);

    expect_at("halt_forward", 2'b11, 1'b0, 1'b0, cyc + 1);
    halt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    halt = 1'b0;
    repeat (3) @(negedge clk);

    check("pending_expectations", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nav_controller.md
# nav_controller

- Upstream decision stage for the wheel-enable block.
- Debounces three obstacle sensors and runs a navigation state machine.
- Drives the 2-bit `state` code that the wheel block decodes into left/right motor enables.
- Turns are open-loop and timed; the block holds each decision for a fixed number of cycles before it re-reads the sensors.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronized samples required before a debounced sensor value changes (≥1).
- `TURN_CYCLES`, 1000: duration of a single turn, in clock cycles (≥1).
- `TIMEOUT_CYCLES`, 5000: BLOCKED dwell time before an escape U-turn (used only with the macro).
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `go` in 1: single-cycle start pulse.
- `halt` in 1: level stop request.
- `obs_left`, `obs_front`, `obs_right` in 1 each: raw, asynchronous obstacle sensors; 1 = obstacle.
- `state` out 2: wheel code.
  - 00 = forward (both wheels on)
  - 01 = turn right (left wheel only)
  - 10 = turn left (right wheel only)
  - 11 = stop
- `busy` out 1: 1 in every FSM state except IDLE.
- `blocked` out 1: 1 only in BLOCKED.

## Operation
**Sensor conditioning** (per sensor)
- 2-flop synchronizer, then a stability counter.
- The debounced value takes the synchronized value once the synchronized value has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
- Any agreement between the two resets the counter.

**FSM** (registered; `state`, `busy`, `blocked` are decoded from registers, glitch-free)
- IDLE: `state`=11. `go`=1 and `halt`=0 → FORWARD.
- FORWARD: `state`=00. If debounced front=1:
  - left=0 → TURN_L;
  - else right=0 → TURN_R;
  - else → BLOCKED.
- TURN_L / TURN_R: `state`=10 / 01.
  - Turn counter loads at entry.
  - Exit to FORWARD after exactly `TURN_CYCLES` cycles in the state.
  - Sensors are ignored while turning.
- BLOCKED: `state`=11. Debounced front=0 → FORWARD.
- Priority: `halt`=1 in any state → IDLE at the next edge. This overrides every other transition, including a turn in progress (the turn counter is cleared).
- Simultaneous `go`+`halt` → stay in IDLE.
- `go` outside IDLE is ignored.
- Front clearing during a turn has no effect until the turn ends.

**Widths**
- Counters are `$clog2(max value + 1)` bits and saturate; they never wrap.

## Timing
- Reset (async assert, sync release): FSM=IDLE; `state`=11; `busy`=0; `blocked`=0; synchronizers, debounced values and all counters = 0.
- Reset mid-turn aborts immediately to IDLE outputs.
- Sensor latency: raw edge held stable → debounced change after 2 + `DEBOUNCE_CYCLES` edges.
  - `state` reflects the decision 1 edge later: `DEBOUNCE_CYCLES`+3 cycles total.
- Pulses shorter than `DEBOUNCE_CYCLES` after synchronization are rejected.
- `go` sampled at edge k → `state`=00 after edge k.
- A turn entered at edge k holds for `TURN_CYCLES` cycles; `state`=00 after edge k+`TURN_CYCLES`.
- `halt` sampled at edge k → `state`=11 after edge k.

## Configuration
- `NAV_TIMEOUT_EN` defined:
  - A dwell counter runs in BLOCKED.
  - If front is still blocked after `TIMEOUT_CYCLES` cycles → TURN_R for 2×`TURN_CYCLES` (U-turn), then FORWARD.
  - `halt` still has priority.
- `NAV_TIMEOUT_EN` undefined:
  - BLOCKED persists indefinitely until front clears or `halt`.
  - No dwell counter is synthesized.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `TURN_CYCLES`=10, `TIMEOUT_CYCLES`=20.
- Reset values: assert `rst_n`=0 mid-cycle → `state`=11, `busy`=0 immediately. Release, pulse `go` → `state`=00 one edge later, `busy`=1.
- Left turn: FORWARD, `obs_front`=1, others 0, held → `state`=10 exactly 7 cycles after the raw edge; 10 cycles later `state`=00.
- Glitch rejection: `obs_front` high for 3 cycles only → `state` stays 00.
- Right turn: `obs_front`=1, `obs_left`=1, `obs_right`=0 → `state`=01.
- All blocked: all three sensors = 1 → `state`=11, `blocked`=1.
  - Drop `obs_front` → `state`=00 7 cycles later.
  - With `NAV_TIMEOUT_EN`: hold all three sensors high instead → `state`=01 for 20 cycles after 20 BLOCKED cycles, then `state`=00.
- Halt mid-turn: `halt`=1 on cycle 5 of TURN_L → `state`=11 next edge, `busy`=0.
  - Simultaneous `go`+`halt` in IDLE → remains 11.
